// File: rtl/alu_pkg.sv
// Shared ALU definitions: slice width, sequencer state encoding and slice-count helper.
package alu_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of SLICE_W-bit slices in a WIDTH-bit operand.
   function automatic int nslice(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/sub_slice_4.sv
// Combinational 4-bit subtract slice: d = a - b - bin, built as a + ~b + ~bin.
module sub_slice_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout
);

   logic [4:0] carry;

   // Ripple chain over the inverted subtrahend; borrow out is the inverted final carry.
   always_comb begin
      carry    = '0;
      d        = '0;
      carry[0] = ~bin;
      for (int i = 0; i < 4; i++) begin
         d[i]       = a[i] ^ ~b[i] ^ carry[i];
         carry[i+1] = (a[i] & ~b[i]) | (a[i] & carry[i]) | (~b[i] & carry[i]);
      end
      bout = ~carry[4];
   end

endmodule

// File: rtl/sub_seq.sv
// Multi-cycle WIDTH-bit subtractor: one 4-bit slice per clock, LSB first,
// borrow registered between slices, valid/ready on both sides.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands; in_ready high
// RUN   | one slice per edge, counter selects slice, borrow carried over
// DONE  | result and flags registered; out_valid high until out_ready
module sub_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int NSLICE = nslice(WIDTH);
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   generate
      if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
         $error("sub_seq: WIDTH must be a non-zero multiple of SLICE_W");
      end
   endgenerate

   state_t             state_q, state_nxt;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   a_q, b_q, work_q, work_nxt, diff_q;
   logic               borrow_q, bout_q, ovf_q, zero_q;
   logic               accept, step, last;
   logic [SLICE_W-1:0] slice_a, slice_b, slice_d;
   logic               slice_bout;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   // Next-state and handshake decode.
   always_comb begin
      state_nxt = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      step      = 1'b0;
      last      = (cnt_q == LAST);
      case (state_q)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counter-indexed slice mux into the single slice instance.
   always_comb begin
      slice_a = a_q[int'(cnt_q)*SLICE_W +: SLICE_W];
      slice_b = b_q[int'(cnt_q)*SLICE_W +: SLICE_W];
   end

   sub_slice_4 u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .bin  (borrow_q),
      .d    (slice_d),
      .bout (slice_bout)
   );

   // Working result with the current slice written back at its index.
   always_comb begin
      work_nxt = work_q;
      work_nxt[int'(cnt_q)*SLICE_W +: SLICE_W] = slice_d;
   end

   // Operand capture, slice stepping, and result publication on the last slice.
   // The visible diff/flags only change when a full result is ready, so they
   // hold steady through IDLE and the next RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         work_q   <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else if (accept) begin
         a_q      <= a;
         b_q      <= b;
         borrow_q <= bin;
         cnt_q    <= '0;
         work_q   <= '0;
      end else if (step) begin
         work_q   <= work_nxt;
         borrow_q <= slice_bout;
         if (last) begin
            cnt_q  <= '0;
            diff_q <= work_nxt;
            bout_q <= slice_bout;
            ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_nxt[WIDTH-1] != a_q[WIDTH-1]);
            zero_q <= (work_nxt == '0);
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_sub_seq.sv
// Self-checking bench for sub_seq: scoreboard of expected results from a
// reference subtraction, compared when the DUT presents out_valid.
module tb_sub_seq;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
      logic         z;
   } exp_t;

   logic         clk, rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] a, b, diff;
   logic         bin, bout, ovf, zero;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   sub_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
      logic [W:0] full;
      exp_t e;
      full = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
      e.d  = full[W-1:0];
      e.bo = full[W];
      e.ov = (ta[W-1] != tb[W-1]) && (e.d[W-1] != ta[W-1]);
      e.z  = (e.d == '0);
      return e;
   endfunction

   task automatic wait_ready();
      int t = 0;
      while (!in_ready && t < 20) begin
         @(posedge clk); #1; t++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wait_ready: in_ready=%b required 1", in_ready);
      end
   endtask

   // One full operation: accept, latency check, optional stall in DONE, compare, consume.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin, input int stall);
      int           lat;
      exp_t         e;
      logic [W-1:0] held;
      wait_ready();
      a = ta; b = tb; bin = tbin; in_valid = 1'b1;
      sb.push_back(model(ta, tb, tbin));
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      n_checks++;
      if (lat != 4 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL latency: edges=%0d out_valid=%b required 4 / 1", lat, out_valid);
      end
      if (sb.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL scoreboard: empty when result appeared");
         return;
      end
      e = sb.pop_front();
      n_checks++;
      if ({diff, bout, ovf, zero} !== {e.d, e.bo, e.ov, e.z}) begin
         n_fail++;
         $display("FAIL result a=%h b=%h bin=%b: got diff=%h bout=%b ovf=%b zero=%b required diff=%h bout=%b ovf=%b zero=%b",
                  ta, tb, tbin, diff, bout, ovf, zero, e.d, e.bo, e.ov, e.z);
      end
      held = diff;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {diff, bout, ovf, zero} !== {e.d, e.bo, e.ov, e.z}) begin
            n_fail++;
            $display("FAIL stall %0d: out_valid=%b in_ready=%b diff=%h bout=%b ovf=%b zero=%b required 1 0 %h %b %b %b",
                     i, out_valid, in_ready, diff, bout, ovf, zero, e.d, e.bo, e.ov, e.z);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== held) begin
         n_fail++;
         $display("FAIL consume: out_valid=%b in_ready=%b diff=%h required 0 1 %h", out_valid, in_ready, diff, held);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({in_ready, out_valid, diff, bout, ovf, zero} !== '0) begin
         n_fail++;
         $display("FAIL reset: in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b zero=%b required all 0",
                  in_ready, out_valid, diff, bout, ovf, zero);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      run_op(16'h1234, 16'h0234, 1'b0, 0);
      run_op(16'h0000, 16'h0001, 1'b0, 0);
      run_op(16'h8000, 16'h0001, 1'b0, 0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
      run_op(16'h0005, 16'h0004, 1'b1, 0);
   endtask

   task automatic test_boundaries();
      run_op(16'hA5C3, 16'hA5C3, 1'b1, 0);
      run_op(16'h0000, 16'h0000, 1'b1, 0);
      run_op(16'hBEEF, 16'h0000, 1'b0, 0);
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
   endtask

   task automatic test_backpressure();
      run_op(16'h00FF, 16'h000F, 1'b0, 3);
   endtask

   task automatic test_reset_mid();
      wait_ready();
      a = 16'hFFFF; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, out_valid, diff, bout, ovf, zero} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b zero=%b required all 0",
                  in_ready, out_valid, diff, bout, ovf, zero);
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold %0d: out_valid=%b required 0", i, out_valid);
         end
      end
      @(negedge clk); rst_n = 1'b1;
      run_op(16'h0003, 16'h0001, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), i % 2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
